fifo_level_buffer: RTL and testbench

FIFO_LEVEL_BUFFER -- requirements
Module: fifo_level_buffer

---
 rtl/fifo_level_buffer_if.sv | 38 +++
 rtl/fifo_level_buffer.sv | 113 +++++++++++
 tb/tb_fifo_level_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_level_buffer_if.sv
// Handshake and status bundle for fifo_level_buffer.
// The master drives requests; the slave is the buffer.
interface fifo_level_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             wr_trigger;
  logic [WIDTH-1:0] wr_data;
  logic             wr_rdy;
  logic             wr_done;
  logic             rd_trigger;
  logic [WIDTH-1:0] rd_data;
  logic             rd_rdy;
  logic             rd_done;
  logic             is_empty;
  logic             is_full;
  logic             almost_empty;
  logic             almost_full;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_trigger, wr_data, rd_trigger,
    input  wr_rdy, wr_done, rd_data, rd_rdy, rd_done,
    input  is_empty, is_full, almost_empty, almost_full,
    input  level, overflow, underflow
  );

  modport slave (
    input  wr_trigger, wr_data, rd_trigger,
    output wr_rdy, wr_done, rd_data, rd_rdy, rd_done,
    output is_empty, is_full, almost_empty, almost_full,
    output level, overflow, underflow
  );
endinterface

// File: rtl/fifo_level_buffer.sv
// Level-tracking FIFO with registered read data,
// done pulses and sticky overflow/underflow flags.
module fifo_level_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic flush,
  input  logic err_clr,
  fifo_level_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [LW-1:0]    level;
  logic [WIDTH-1:0] rd_q;
  logic             wr_done_q;
  logic             rd_done_q;
  logic             ovf_q;
  logic             unf_q;

  logic empty;
  logic full;
  logic wr_rdy;
  logic rd_rdy;
  logic wr_acc;
  logic rd_acc;
  logic wr_err;
  logic rd_err;

  assign empty  = (level == '0);
  assign full   = (level == FULL_L);
  assign wr_rdy = !full || bus.rd_trigger;
  assign rd_rdy = !empty;

  assign wr_acc = clk_en && !flush && bus.wr_trigger && wr_rdy;
  assign rd_acc = clk_en && !flush && bus.rd_trigger && rd_rdy;
  assign wr_err = clk_en && bus.wr_trigger && !wr_rdy;
  assign rd_err = clk_en && bus.rd_trigger && !rd_rdy;

  // Array is left uninitialised; reset only clears the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[tail] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      level     <= '0;
      rd_q      <= '0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        level     <= '0;
        wr_done_q <= 1'b0;
        rd_done_q <= 1'b0;
      end else begin
        wr_done_q <= wr_acc;
        rd_done_q <= rd_acc;
        if (wr_acc) tail <= tail + AW'(1);
        if (rd_acc) begin
          head <= head + AW'(1);
          rd_q <= mem[head];
        end
        unique case ({wr_acc, rd_acc})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // A fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clk_en) begin
      if (wr_err)       ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (rd_err)       unf_q <= 1'b1;
      else if (err_clr) unf_q <= 1'b0;
    end
  end

  assign bus.wr_rdy       = wr_rdy;
  assign bus.rd_rdy       = rd_rdy;
  assign bus.wr_done      = wr_done_q;
  assign bus.rd_done      = rd_done_q;
  assign bus.rd_data      = rd_q;
  assign bus.level        = level;
  assign bus.is_empty     = empty;
  assign bus.is_full      = full;
  assign bus.almost_full  = (level >= AF_L);
  assign bus.almost_empty = (level <= AE_L);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_level_buffer.sv
// Bench for fifo_level_buffer: vector table, corner
// sequences and random traffic against a queue model.
module tb_fifo_level_buffer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic flush;
  logic err_clr;

  fifo_level_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_level_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH),
    .AF_THRESH(3), .AE_THRESH(1)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .flush(flush), .err_clr(err_clr), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int q[$];
  int m_rd;
  bit m_wd, m_rdn, m_ov, m_un;

  typedef struct {
    bit ce, fl, wr, rd, ec;
    int data;
    int lvl, rdd;
    bit wd, rdn, ov, un;
  } vec_t;

  vec_t vt[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = 0; m_wd = 0; m_rdn = 0; m_ov = 0; m_un = 0;
  endtask

  task automatic model_edge(bit ce, bit fl, bit wr, bit rd, bit ec, int d);
    bit full, empty, wok, racc, wacc;
    if (!ce) return;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    wok   = !full || rd;
    if (fl) begin
      q.delete();
      m_wd = 0; m_rdn = 0;
    end else begin
      racc = rd && !empty;
      wacc = wr && wok;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(d);
      m_wd = wacc; m_rdn = racc;
    end
    if (wr && !wok) m_ov = 1; else if (ec) m_ov = 0;
    if (rd && empty) m_un = 1; else if (ec) m_un = 0;
  endtask

  task automatic model_check(string tag);
    int n;
    n = q.size();
    chk({tag, ".level"}, int'(bus.level), n);
    chk({tag, ".rd_data"}, int'(bus.rd_data), m_rd);
    chk({tag, ".wr_done"}, int'(bus.wr_done), int'(m_wd));
    chk({tag, ".rd_done"}, int'(bus.rd_done), int'(m_rdn));
    chk({tag, ".overflow"}, int'(bus.overflow), int'(m_ov));
    chk({tag, ".underflow"}, int'(bus.underflow), int'(m_un));
    chk({tag, ".is_empty"}, int'(bus.is_empty), int'(n == 0));
    chk({tag, ".is_full"}, int'(bus.is_full), int'(n == DEPTH));
    chk({tag, ".almost_full"}, int'(bus.almost_full), int'(n >= 3));
    chk({tag, ".almost_empty"}, int'(bus.almost_empty), int'(n <= 1));
    chk({tag, ".rd_rdy"}, int'(bus.rd_rdy), int'(n != 0));
    chk({tag, ".wr_rdy"}, int'(bus.wr_rdy),
        int'(n != DEPTH || bus.rd_trigger));
  endtask

  task automatic step(string tag, bit ce, bit fl, bit wr, bit rd,
                      bit ec, int d);
    clk_en = ce; flush = fl; err_clr = ec;
    bus.wr_trigger = wr; bus.rd_trigger = rd;
    bus.wr_data = WIDTH'(d);
    @(posedge clk);
    model_edge(ce, fl, wr, rd, ec, d);
    #1;
    model_check(tag);
  endtask

  task automatic idle_inputs();
    clk_en = 1; flush = 0; err_clr = 0;
    bus.wr_trigger = 0; bus.rd_trigger = 0; bus.wr_data = '0;
  endtask

  task automatic add(bit ce, bit fl, bit wr, bit rd, bit ec, int d,
                     int lvl, int rdd, bit wd, bit rdn, bit ov, bit un);
    vec_t v;
    v.ce = ce; v.fl = fl; v.wr = wr; v.rd = rd; v.ec = ec;
    v.data = d; v.lvl = lvl; v.rdd = rdd;
    v.wd = wd; v.rdn = rdn; v.ov = ov; v.un = un;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    reset = 0;
    #3;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    model_reset();
    #2;
    model_check("reset");

    //  ce fl wr rd ec data  lvl rdd wd rdn ov un
    add(1, 0, 1, 0, 0, 1,    1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 2,    2, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 3,    3, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 4,    4, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 5,    4, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0,    4, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0,    3, 1, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0,    2, 2, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0,    1, 3, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0,    0, 4, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0,    0, 4, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 7,    1, 4, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 8,    1, 4, 1, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0,    1, 4, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 8,    2, 4, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 9,    3, 4, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 10,   0, 4, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0,    0, 4, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0,    0, 4, 0, 0, 0, 0);

    @(negedge clk);
    reset = 1;
    for (int i = 0; i < vt.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(t, vt[i].ce, vt[i].fl, vt[i].wr, vt[i].rd, vt[i].ec,
           vt[i].data);
      chk({t, ".tlevel"}, int'(bus.level), vt[i].lvl);
      chk({t, ".trd_data"}, int'(bus.rd_data), vt[i].rdd);
      chk({t, ".twr_done"}, int'(bus.wr_done), int'(vt[i].wd));
      chk({t, ".trd_done"}, int'(bus.rd_done), int'(vt[i].rdn));
      chk({t, ".tovf"}, int'(bus.overflow), int'(vt[i].ov));
      chk({t, ".tunf"}, int'(bus.underflow), int'(vt[i].un));
    end

    // pointer wrap
    step("wrap", 1, 0, 1, 0, 0, 1);
    step("wrap", 1, 0, 1, 0, 0, 2);
    step("wrap", 1, 0, 1, 0, 0, 3);
    step("wrap", 1, 0, 0, 1, 0, 0);
    chk("wrap.first", int'(bus.rd_data), 1);
    step("wrap", 1, 0, 1, 0, 0, 4);
    step("wrap", 1, 0, 1, 0, 0, 5);
    for (int i = 0; i < 4; i++) begin
      step("wrap_rd", 1, 0, 0, 1, 0, 0);
      chk("wrap.data", int'(bus.rd_data), i + 2);
    end

    // full with simultaneous read and write
    for (int i = 1; i <= 4; i++) step("fill", 1, 0, 1, 0, 0, i);
    step("full_rw", 1, 0, 1, 1, 0, 9);
    chk("full_rw.rd_data", int'(bus.rd_data), 1);
    chk("full_rw.level", int'(bus.level), 4);
    chk("full_rw.wr_done", int'(bus.wr_done), 1);
    chk("full_rw.rd_done", int'(bus.rd_done), 1);
    begin
      int exp_seq[4] = '{2, 3, 4, 9};
      for (int i = 0; i < 4; i++) begin
        step("full_rw_rd", 1, 0, 0, 1, 0, 0);
        chk("full_rw.seq", int'(bus.rd_data), exp_seq[i]);
      end
    end
    step("clr", 1, 0, 0, 0, 1, 0);

    // asynchronous reset between edges at level 2
    step("pre_rst", 1, 0, 1, 0, 0, 33);
    step("pre_rst", 1, 0, 1, 0, 0, 44);
    step("pre_rst", 1, 0, 0, 1, 0, 0);
    step("pre_rst", 1, 0, 1, 0, 0, 55);
    idle_inputs();
    chk("pre_rst.level", int'(bus.level), 2);
    #2;
    reset = 0;
    #1;
    chk("arst.level", int'(bus.level), 0);
    chk("arst.is_empty", int'(bus.is_empty), 1);
    chk("arst.is_full", int'(bus.is_full), 0);
    chk("arst.wr_rdy", int'(bus.wr_rdy), 1);
    chk("arst.rd_rdy", int'(bus.rd_rdy), 0);
    chk("arst.rd_data", int'(bus.rd_data), 0);
    chk("arst.done", int'(bus.wr_done || bus.rd_done), 0);
    chk("arst.ae_af", int'({bus.almost_empty, bus.almost_full}), 2);
    model_reset();
    @(negedge clk);
    reset = 1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit ce, fl, wr, rd, ec;
      ce = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 29) == 0);
      wr = $urandom_range(0, 1);
      rd = $urandom_range(0, 1);
      ec = ($urandom_range(0, 9) == 0);
      step("rand", ce, fl, wr, rd, ec, int'($urandom_range(0, 255)));
      if (i == 200) do_reset();
    end
    model_check("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
